// File: rtl/pack_buffer_ring.sv
// pack_buffer_ring: ring of NUM_BANKS pack banks between the frame assembler
// (IN_W-bit words) and the bit-serial modulator front end (OUT_W-bit slices).
// Each pack boundary takes the oldest complete bank. If no bank is complete,
// the block emits a blank pack so that the output stream never starves.
// Optional build macro PACK_BUF_MSB_FIRST_EN: each word is slice-reversed
// before storage, so the most significant slice of every word goes out first.
module pack_buffer_ring #(
    parameter int                PACK_BITS   = 1976,
    parameter int                IN_W        = 8,
    parameter int                OUT_W       = 1,
    parameter int                NUM_BANKS   = 4,
    parameter logic [OUT_W-1:0]  BLANK_SLICE = {OUT_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [IN_W-1:0]                  i_data,
    input  logic                             i_abort,
    output logic                             o_valid,
    input  logic                             i_out_ready,
    output logic [OUT_W-1:0]                 o_data,
    output logic                             o_pack_start,
    output logic                             o_blank,
    output logic [$clog2(NUM_BANKS+1)-1:0]   o_fill_count,
    output logic [CNT_W-1:0]                 o_underrun_cnt
);

    localparam int WORDS = PACK_BITS / IN_W;
    localparam int RATIO = IN_W / OUT_W;
    localparam int FW    = $clog2(NUM_BANKS + 1);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
    localparam logic [SW-1:0] LAST_SUB  = SW'(RATIO - 1);
    localparam logic [FW-1:0] FULL_FILL = FW'(NUM_BANKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

`ifdef PACK_BUF_MSB_FIRST_EN
    // Reverse the order of the OUT_W-bit slices inside one word.
    function automatic logic [IN_W-1:0] slice_rev(input logic [IN_W-1:0] w);
        logic [IN_W-1:0] r;
        r = {IN_W{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            r[k*OUT_W +: OUT_W] = w[(RATIO-1-k)*OUT_W +: OUT_W];
        end
        return r;
    endfunction
`endif

    logic [IN_W-1:0]  mem_r [NUM_BANKS][WORDS];

    logic [BW-1:0]    wr_bank_r;
    logic [WW-1:0]    wr_word_r;
    logic [FW-1:0]    fill_r;
    logic             ready_r;
    state_t           state_r;
    logic [BW-1:0]    rd_bank_r;
    logic [WW-1:0]    rd_word_r;
    logic [SW-1:0]    rd_sub_r;
    logic             valid_r;
    logic [OUT_W-1:0] data_r;
    logic             start_r;
    logic             blank_r;
    logic [CNT_W-1:0] under_r;

    logic             wr_fire_s;
    logic             wr_last_s;
    logic [IN_W-1:0]  store_word_s;
    state_t           state_nxt_s;
    logic             advance_s;
    logic             pack_end_s;
    logic             new_pack_s;
    logic             rd_rel_s;
    logic             pick_blank_s;
    logic             nxt_blank_s;
    logic [BW-1:0]    nxt_bank_s;
    logic [WW-1:0]    nxt_word_s;
    logic [SW-1:0]    nxt_sub_s;
    logic [IN_W-1:0]  mem_word_s;
    logic [OUT_W-1:0] nxt_slice_s;
    logic [FW-1:0]    fill_nxt_s;

    // Write-side acceptance and the word as it is stored in the bank.
    always_comb begin
        wr_fire_s = i_valid & ready_r & ~i_abort;
        wr_last_s = wr_fire_s & (wr_word_r == LAST_WORD);
`ifdef PACK_BUF_MSB_FIRST_EN
        store_word_s = slice_rev(i_data);
`else
        store_word_s = i_data;
`endif
    end

    // Read-side sequencing: the next slice position, the boundary decision and the slice value.
    always_comb begin
        state_nxt_s = state_r;
        advance_s   = 1'b0;
        pack_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                state_nxt_s = ST_STREAM;
                advance_s   = 1'b1;
            end
            ST_STREAM: begin
                advance_s  = i_out_ready;
                pack_end_s = i_out_ready & (rd_word_r == LAST_WORD) & (rd_sub_r == LAST_SUB);
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        new_pack_s = (state_r == ST_FETCH) | pack_end_s;
        rd_rel_s   = pack_end_s & ~blank_r;

        if (rd_rel_s) begin
            nxt_bank_s = (rd_bank_r == LAST_BANK) ? {BW{1'b0}} : rd_bank_r + BW'(1);
        end else begin
            nxt_bank_s = rd_bank_r;
        end

        // The bank being released does not count; a bank completing this cycle is not visible yet.
        pick_blank_s = (fill_r == {FW{1'b0}}) | (rd_rel_s & (fill_r == FW'(1)));
        nxt_blank_s  = new_pack_s ? pick_blank_s : blank_r;

        if (new_pack_s) begin
            nxt_word_s = {WW{1'b0}};
            nxt_sub_s  = {SW{1'b0}};
        end else if (rd_sub_r == LAST_SUB) begin
            nxt_word_s = rd_word_r + WW'(1);
            nxt_sub_s  = {SW{1'b0}};
        end else begin
            nxt_word_s = rd_word_r;
            nxt_sub_s  = rd_sub_r + SW'(1);
        end

        mem_word_s  = mem_r[nxt_bank_s][nxt_word_s];
        nxt_slice_s = {OUT_W{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            nxt_slice_s = (nxt_sub_s == SW'(k)) ? mem_word_s[k*OUT_W +: OUT_W] : nxt_slice_s;
        end
        if (nxt_blank_s) begin
            nxt_slice_s = BLANK_SLICE;
        end else begin
            nxt_slice_s = nxt_slice_s;
        end

        if (wr_last_s & ~rd_rel_s) begin
            fill_nxt_s = fill_r + FW'(1);
        end else if (rd_rel_s & ~wr_last_s) begin
            fill_nxt_s = fill_r - FW'(1);
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Bank storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_fire_s) begin
            mem_r[wr_bank_r][wr_word_r] <= store_word_s;
        end
    end

    // Write pointers: abort drops the partial pack, completion moves to the next bank.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_bank_r <= {BW{1'b0}};
            wr_word_r <= {WW{1'b0}};
        end else if (i_abort) begin
            wr_word_r <= {WW{1'b0}};
        end else if (wr_last_s) begin
            wr_word_r <= {WW{1'b0}};
            wr_bank_r <= (wr_bank_r == LAST_BANK) ? {BW{1'b0}} : wr_bank_r + BW'(1);
        end else if (wr_fire_s) begin
            wr_word_r <= wr_word_r + WW'(1);
        end
    end

    // Fill level of complete, unread banks and the registered write-side ready.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill_r  <= {FW{1'b0}};
            ready_r <= 1'b1;
        end else begin
            fill_r  <= fill_nxt_s;
            ready_r <= (fill_nxt_s < FULL_FILL);
        end
    end

    // Read state register, read pointers and registered slice outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            rd_bank_r <= {BW{1'b0}};
            rd_word_r <= {WW{1'b0}};
            rd_sub_r  <= {SW{1'b0}};
            valid_r   <= 1'b0;
            data_r    <= {OUT_W{1'b0}};
            start_r   <= 1'b0;
            blank_r   <= 1'b0;
            under_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= valid_r | (state_r == ST_FETCH);
            if (advance_s) begin
                rd_bank_r <= nxt_bank_s;
                rd_word_r <= nxt_word_s;
                rd_sub_r  <= nxt_sub_s;
                data_r    <= nxt_slice_s;
                start_r   <= new_pack_s;
                blank_r   <= nxt_blank_s;
                if (new_pack_s && pick_blank_s && (under_r != {CNT_W{1'b1}})) begin
                    under_r <= under_r + CNT_W'(1);
                end
            end
        end
    end

    assign o_ready        = ready_r;
    assign o_valid        = valid_r;
    assign o_data         = data_r;
    assign o_pack_start   = start_r;
    assign o_blank        = blank_r;
    assign o_fill_count   = fill_r;
    assign o_underrun_cnt = under_r;

endmodule

// File: tb/tb_pack_buffer_ring.sv
// Testbench for pack_buffer_ring: a pack-level reference model (queues of
// complete packs, a current pack and its slice index) predicts every output on
// every cycle. Directed phases pin the model with hand-computed values, and a
// randomized phase follows.
module tb_pack_buffer_ring;

    localparam int PACK_BITS = 1976;
    localparam int IN_W      = 8;
    localparam int OUT_W     = 2;
    localparam int NUM_BANKS = 4;
    localparam int CNT_W     = 16;
    localparam int WORDS     = PACK_BITS / IN_W;
    localparam int SLICES    = PACK_BITS / OUT_W;
    localparam int RATIO     = IN_W / OUT_W;
    localparam int FW        = $clog2(NUM_BANKS + 1);
    localparam logic [OUT_W-1:0] BLANK = 2'b10;

    logic             i_clk;
    logic             i_reset_n;
    logic             i_valid;
    logic             o_ready;
    logic [IN_W-1:0]  i_data;
    logic             i_abort;
    logic             o_valid;
    logic             i_out_ready;
    logic [OUT_W-1:0] o_data;
    logic             o_pack_start;
    logic             o_blank;
    logic [FW-1:0]    o_fill_count;
    logic [CNT_W-1:0] o_underrun_cnt;

    pack_buffer_ring #(
        .PACK_BITS(PACK_BITS), .IN_W(IN_W), .OUT_W(OUT_W),
        .NUM_BANKS(NUM_BANKS), .BLANK_SLICE(BLANK), .CNT_W(CNT_W)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_abort(i_abort), .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_data(o_data), .o_pack_start(o_pack_start), .o_blank(o_blank),
        .o_fill_count(o_fill_count), .o_underrun_cnt(o_underrun_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk;
    int n_fail;

    logic            drv_valid;
    logic            drv_abort;
    logic            drv_ready;
    logic [IN_W-1:0] drv_data;
    bit              acc_flag;

    // Reference model state
    logic [IN_W-1:0] wr_part[$];
    logic [IN_W-1:0] comp_q[$];
    int              comp_n;
    logic [IN_W-1:0] m_pack[WORDS];
    bit              m_blank;
    int              m_idx;
    int              m_k;
    int              m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_slice(input logic [IN_W-1:0] w, input int sub);
        int pos;
        logic [IN_W-1:0] t;
`ifdef PACK_BUF_MSB_FIRST_EN
        pos = RATIO - 1 - sub;
`else
        pos = sub;
`endif
        t = w >> (pos * OUT_W);
        return t[OUT_W-1:0];
    endfunction

    function automatic int exp_fill();
        return comp_n + (((m_k >= 2) && !m_blank) ? 1 : 0);
    endfunction

    task automatic model_reset();
        wr_part.delete();
        comp_q.delete();
        comp_n  = 0;
        m_blank = 1'b0;
        m_idx   = 0;
        m_k     = 0;
        m_cnt   = 0;
    endtask

    // Start a new pack: oldest complete pack if any, otherwise a blank one.
    task automatic boundary();
        m_idx = 0;
        if (comp_n > 0) begin
            for (int w = 0; w < WORDS; w++) m_pack[w] = comp_q.pop_front();
            comp_n--;
            m_blank = 1'b0;
        end else begin
            m_blank = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    // Called at a falling edge: compare outputs, apply inputs, advance model, wait one clock.
    task automatic cycle();
        int f;
        bit rdy;
        f   = exp_fill();
        rdy = (f < NUM_BANKS);
        chk("ready", 32'(o_ready), 32'(rdy));
        chk("fill_count", 32'(o_fill_count), 32'(f));
        chk("underrun_cnt", 32'(o_underrun_cnt), 32'(m_cnt));
        if (m_k < 2) begin
            chk("valid_pre", 32'(o_valid), 32'd0);
            chk("data_pre", 32'(o_data), 32'd0);
            chk("pack_start_pre", 32'(o_pack_start), 32'd0);
            chk("blank_pre", 32'(o_blank), 32'd0);
        end else begin
            chk("valid", 32'(o_valid), 32'd1);
            chk("pack_start", 32'(o_pack_start), 32'(m_idx == 0));
            chk("blank", 32'(o_blank), 32'(m_blank));
            if (m_blank) chk("data_blank", 32'(o_data), 32'(BLANK));
            else chk("data", 32'(o_data), 32'(exp_slice(m_pack[m_idx / RATIO], m_idx % RATIO)));
        end
        i_valid     = drv_valid;
        i_data      = drv_data;
        i_abort     = drv_abort;
        i_out_ready = drv_ready;
        acc_flag = drv_valid && rdy && !drv_abort;
        if (m_k == 1) begin
            boundary();
        end else if ((m_k >= 2) && drv_ready) begin
            if (m_idx == SLICES - 1) boundary();
            else m_idx++;
        end
        if (drv_abort) begin
            wr_part.delete();
        end else if (acc_flag) begin
            wr_part.push_back(drv_data);
            if (wr_part.size() == WORDS) begin
                foreach (wr_part[i]) comp_q.push_back(wr_part[i]);
                comp_n++;
                wr_part.delete();
            end
        end
        if (m_k < 2) m_k++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        drv_valid = 1'b0; drv_abort = 1'b0; drv_ready = 1'b0; drv_data = '0;
        i_valid = 1'b0; i_abort = 1'b0; i_out_ready = 1'b0; i_data = '0;
        i_reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_fill", 32'(o_fill_count), 32'd0);
        chk("rst_underrun", 32'(o_underrun_cnt), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_pack_start", 32'(o_pack_start), 32'd0);
        chk("rst_blank", 32'(o_blank), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic put_word(input logic [IN_W-1:0] d, input string tag);
        bit done;
        done = 1'b0;
        drv_valid = 1'b1;
        drv_data  = d;
        for (int t = 0; t < 6000; t++) begin
            cycle();
            if (acc_flag) begin
                done = 1'b1;
                break;
            end
        end
        drv_valid = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s: word not accepted within budget, required acceptance", tag);
        end
    endtask

    task automatic put_words(input logic [IN_W-1:0] first, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (i == 0) put_word(first, tag);
            else put_word(IN_W'($urandom_range(255, 0)), tag);
        end
    endtask

    task automatic wait_start(input bit want_blank, input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (o_pack_start && (o_blank == want_blank)) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no pack start with blank=%0d within budget", tag, want_blank);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sl[4];
        n_chk = 0;
        n_fail = 0;
        drv_valid = 1'b0; drv_abort = 1'b0; drv_ready = 1'b0; drv_data = '0;
        i_valid = 1'b0; i_abort = 1'b0; i_out_ready = 1'b0; i_data = '0;
        i_reset_n = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Idle start: blank packs only, underrun counting 1, 2, 3
        drv_ready = 1'b1;
        cycle();
        chk("t1_valid_cycle1", 32'(o_valid), 32'd0);
        cycle();
        chk("t1_valid_cycle2", 32'(o_valid), 32'd1);
        chk("t1_start0", 32'(o_pack_start), 32'd1);
        chk("t1_blank0", 32'(o_blank), 32'd1);
        chk("t1_data0", 32'(o_data), 32'(BLANK));
        chk("t1_cnt1", 32'(o_underrun_cnt), 32'd1);
        repeat (SLICES) cycle();
        chk("t1_start1", 32'(o_pack_start), 32'd1);
        chk("t1_cnt2", 32'(o_underrun_cnt), 32'd2);
        repeat (SLICES) cycle();
        chk("t1_start2", 32'(o_pack_start), 32'd1);
        chk("t1_cnt3", 32'(o_underrun_cnt), 32'd3);

        // One real pack whose first byte is A5
`ifdef PACK_BUF_MSB_FIRST_EN
        exp_sl = '{2, 2, 1, 1};
`else
        exp_sl = '{1, 1, 2, 2};
`endif
        put_words(8'hA5, WORDS, "t2_write");
        wait_start(1'b0, 3000, "t2_real_start");
        chk("t2_fill_at_start", 32'(o_fill_count), 32'd1);
        for (int s = 0; s < 4; s++) begin
            chk("t2_first_slices", 32'(o_data), 32'(exp_sl[s]));
            cycle();
        end
        wait_start(1'b1, 3000, "t2_blank_after");
        chk("t2_fill_drained", 32'(o_fill_count), 32'd0);

        // Ring full with the consumer stalled
        drv_ready = 1'b0;
        for (int p = 0; p < NUM_BANKS; p++) put_words(IN_W'(8'h10 + p), WORDS, "t3_write");
        chk("t3_ready_low", 32'(o_ready), 32'd0);
        chk("t3_fill_full", 32'(o_fill_count), 32'(NUM_BANKS));
        drv_valid = 1'b1;
        drv_data  = 8'h5C;
        repeat (30) cycle();
        chk("t3_held_ready", 32'(o_ready), 32'd0);
        chk("t3_held_fill", 32'(o_fill_count), 32'(NUM_BANKS));
        drv_ready = 1'b1;
        put_word(8'h5C, "t3_fifth_first");
        chk("t3_fill_after_drain", 32'(o_fill_count), 32'(NUM_BANKS - 1));
        put_words(8'h77, WORDS - 1, "t3_fifth_rest");
        wait_start(1'b1, 8000, "t3_drain");
        chk("t3_fill_drained", 32'(o_fill_count), 32'd0);

        // Abort at word 100, then a complete new pack
        drv_ready = 1'b0;
        put_words(8'hEE, 100, "t4_partial");
        drv_abort = 1'b1;
        drv_valid = 1'b1;
        drv_data  = 8'hEE;
        cycle();
        drv_abort = 1'b0;
        drv_valid = 1'b0;
        chk("t4_fill_after_abort", 32'(o_fill_count), 32'd0);
        put_words(8'h3C, WORDS, "t4_new_pack");
        chk("t4_fill_plus_one", 32'(o_fill_count), 32'd1);
        drv_ready = 1'b1;
        wait_start(1'b0, 3000, "t4_real_start");
        wait_start(1'b1, 3000, "t4_blank_after");

        // Randomized traffic, with a reset in the middle of operation
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) do_reset();
            for (int c = 0; c < 12000; c++) begin
                if (ph == 0) drv_valid = ($urandom_range(1, 0) == 1);
                else drv_valid = ($urandom_range(7, 0) == 0);
                drv_ready = ($urandom_range(1, 0) == 1);
                drv_abort = ($urandom_range(1999, 0) == 0);
                drv_data  = IN_W'($urandom_range(255, 0));
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
